// File: rtl/vector_pkg.sv
// Shared constants for the RAM-disk (kvaz) bank mapper: 8080 status word
// bit positions, mapping control register fields and the port address.
package vector_pkg;

  // 8080 status word bit indices (valid on the data bus while SYNC is high)
  localparam int ST_INTA  = 0;
  localparam int ST_WO_N  = 1;
  localparam int ST_STACK = 2;
  localparam int ST_OUT   = 4;
  localparam int ST_M1    = 5;
  localparam int ST_INP   = 6;
  localparam int ST_MEMR  = 7;

  // Mapping control register fields
  localparam int CFG_STACK_PAGE_LSB = 0;  // [1:0]
  localparam int CFG_WIN_PAGE_LSB   = 2;  // [3:2]
  localparam int CFG_STACK_EN       = 4;
  localparam int CFG_WIN_EN         = 5;

  // RAM-disk control port address
  localparam logic [7:0] PORT_RAMDISK = 8'h10;

  // Bank value 0 is main RAM; kvaz pages 0..3 map to banks 1..4.
  function automatic logic [2:0] page_bank(input logic [1:0] page);
    return {1'b0, page} + 3'd1;
  endfunction

endpackage

// File: rtl/kvaz_decode.sv
// Pure combinational bank selection from the new status word, the CPU
// address and the effective mapping register. Stack beats window; I/O and
// interrupt-acknowledge cycles always go to main RAM.
module kvaz_decode
  import vector_pkg::*;
#(
  parameter logic [15:0] WIN_LO = 16'hA000,
  parameter logic [15:0] WIN_HI = 16'hDFFF
) (
  input  logic [7:0]  st,
  input  logic [15:0] a,
  input  logic [7:0]  cfg,
  output logic [2:0]  bank
);

  logic io_cycle;
  logic win_hit;
  logic unused_bits;

  assign io_cycle    = st[ST_OUT] | st[ST_INP] | st[ST_INTA];
  assign win_hit     = (a >= WIN_LO) && (a <= WIN_HI);
  assign unused_bits = ^{st[7], st[5], st[3], st[1], cfg[7:6]};

  // Priority: I/O/INTA -> main RAM, then stack, then data window.
  always_comb begin
    bank = 3'd0;
    if (io_cycle) begin
      bank = 3'd0;
    end else if (st[ST_STACK] && cfg[CFG_STACK_EN]) begin
      bank = page_bank(cfg[CFG_STACK_PAGE_LSB +: 2]);
    end else if (win_hit && cfg[CFG_WIN_EN]) begin
      bank = page_bank(cfg[CFG_WIN_PAGE_LSB +: 2]);
    end
  end

endmodule

// File: rtl/kvaz_mapper.sv
// RAM-disk bank mapper. Latches the 8080 status word on every SYNC, catches
// OUT writes to the kvaz control port into a pending register, commits the
// pending value on the following SYNC and registers SRAM_ADDR[17:15] for the
// whole machine cycle. Video fetches are forced to main RAM combinationally.
//
// Handshake: there is no valid/ready pair here; every update is qualified by
// cpu_ce. A status latch happens on cpu_ce & sync, a port write is captured on
// cpu_ce & ~wr_n while the latched status says OUT to the decoded port.
module kvaz_mapper
  import vector_pkg::*;
#(
  parameter logic [7:0]  PORT_ADDR = PORT_RAMDISK,
  parameter logic [15:0] WIN_LO    = 16'hA000,
  parameter logic [15:0] WIN_HI    = 16'hDFFF
) (
  input  logic        clk24,
  input  logic        mreset_n,
  input  logic        cpu_ce,
  input  logic        sync,
  input  logic        wr_n,
  input  logic [15:0] a,
  input  logic [7:0]  dout,
  input  logic        video_slice,
  output logic [2:0]  bank,
  output logic [7:0]  cfg,
  output logic        stack_cycle
);

  logic [7:0] st_q;
  logic [5:0] port_a_q;   // a[7:2] of the current machine cycle
  logic [7:0] cfg_q;
  logic [7:0] cfg_pend_q;
  logic       pend_q;
  logic [2:0] bank_q;

  logic       sync_stb;
  logic       port_hit;
  logic       wr_stb;
  logic [7:0] cfg_eff;
  logic [2:0] bank_d;

  assign sync_stb = cpu_ce & sync;
  assign port_hit = st_q[ST_OUT] & (port_a_q == PORT_ADDR[7:2]);
  assign wr_stb   = cpu_ce & ~wr_n & port_hit;

  // A pending write takes effect in the same SYNC that commits it, so the
  // machine cycle right after the OUT already sees the new mapping.
  assign cfg_eff = pend_q ? cfg_pend_q : cfg_q;

  kvaz_decode #(
    .WIN_LO (WIN_LO),
    .WIN_HI (WIN_HI)
  ) u_decode (
    .st   (dout),
    .a    (a),
    .cfg  (cfg_eff),
    .bank (bank_d)
  );

  // Status/address latch, pending write capture, commit and bank register.
  always_ff @(posedge clk24 or negedge mreset_n) begin
    if (!mreset_n) begin
      st_q       <= 8'h00;
      port_a_q   <= 6'd0;
      cfg_q      <= 8'h00;
      cfg_pend_q <= 8'h00;
      pend_q     <= 1'b0;
      bank_q     <= 3'd0;
    end else if (sync_stb) begin
      st_q     <= dout;
      port_a_q <= a[7:2];
      bank_q   <= bank_d;
      if (pend_q) begin
        cfg_q  <= cfg_pend_q;
        pend_q <= 1'b0;
      end
    end else if (wr_stb) begin
      cfg_pend_q <= dout;
      pend_q     <= 1'b1;
    end
  end

  assign bank        = video_slice ? 3'd0 : bank_q;
  assign cfg         = cfg_q;
  assign stack_cycle = st_q[ST_STACK];

endmodule
